// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the word-level sequence detector.
// Defines the controller/detector state encodings and the detector next-state and match logic.
package seq_det_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } ctrl_state_t;

    typedef enum logic [2:0] {
        D0, D1, D2, D3, D4, D5, D6, D7
    } det_state_t;

    localparam det_state_t MATCH_STATES [2] = '{D4, D7};

    function automatic logic is_match(input det_state_t s);
        logic m;
        m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (s == MATCH_STATES[i]) begin
                m = 1'b1;
            end
        end
        return m;
    endfunction

    // D4 tracks a trailing 1111, D7 a trailing 1001; the rest encode partial prefixes.
    function automatic det_state_t det_next(input det_state_t s, input logic w);
        det_state_t n;
        case (s)
            D0:      n = w ? D1 : D0;
            D1:      n = w ? D2 : D5;
            D2:      n = w ? D3 : D5;
            D3:      n = w ? D4 : D5;
            D4:      n = w ? D4 : D5;
            D5:      n = w ? D1 : D6;
            D6:      n = w ? D7 : D0;
            D7:      n = w ? D2 : D5;
            default: n = D0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial Moore detector for 1111 / 1001 with overlap.
// z is registered alongside the state, so it always reflects the current state.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic w,
    output logic z
);

    det_state_t state_reg;
    det_state_t state_next;
    logic       z_reg;

    always_comb begin
        state_next = det_next(state_reg, w);
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_reg <= D0;
            z_reg     <= 1'b0;
        end else if (en) begin
            state_reg <= state_next;
            z_reg     <= is_match(state_next);
        end
    end

    assign z = z_reg;

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-level controller: shifts a word MSB-first through seq_det_core and
// returns the per-bit hit map and hit count over a valid/ready handshake.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_map,
    output logic [CW-1:0]    out_hits,
    output logic             busy
);

    ctrl_state_t      state_reg;
    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] map_reg;
    logic [WIDTH-1:0] sample_mask;
    logic [CW-1:0]    k_reg;
    logic [CW-1:0]    hits_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic             accept;
    logic             det_en;
    logic             det_z;

    assign in_ready = (state_reg == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign det_en   = (state_reg == SHIFT);

    seq_det_core u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (det_en),
        .w     (sr_reg[WIDTH-1]),
        .z     (det_z)
    );

    // z lags the consumed bit by one cycle, so SHIFT step k records bit WIDTH-k.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            if (gi == 0) begin : g_drain
                assign sample_mask[gi] = (state_reg == DRAIN);
            end else begin : g_shift
                assign sample_mask[gi] = (state_reg == SHIFT) && (k_reg == CW'(WIDTH - gi));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            sr_reg        <= '0;
            map_reg       <= '0;
            hits_reg      <= '0;
            k_reg         <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        sr_reg    <= in_data;
                        map_reg   <= '0;
                        hits_reg  <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    k_reg     <= '0;
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    sr_reg <= {sr_reg[WIDTH-2:0], 1'b0};
                    k_reg  <= k_reg + CW'(1);
                    if (k_reg == CW'(WIDTH - 1)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (|sample_mask) begin
                map_reg  <= (map_reg & ~sample_mask) | (sample_mask & {WIDTH{det_z}});
                hits_reg <= hits_reg + {{(CW-1){1'b0}}, det_z};
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_map   = map_reg;
    assign out_hits  = hits_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed, table-driven bench for seq_det_ctrl with hand-computed hit maps.
module tb_seq_det_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = 4;
    localparam int LAT   = WIDTH + 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_map;
    logic [CW-1:0]    out_hits;
    logic             busy;

    seq_det_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_map   (out_map),
        .out_hits  (out_hits),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] map;
        logic [CW-1:0]    hits;
    } vec_t;

    vec_t vecs [10];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called at the negedge of the cycle after acceptance; returns the cycle index of out_valid.
    task automatic wait_result(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_word(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] em,
                            input logic [CW-1:0] eh, input string nm);
        int lat;
        in_data  = d;
        in_valid = 1'b1;
        wait_ready();
        check({nm, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        check({nm, " latency"}, lat, LAT);
        check({nm, " map"}, out_map, em);
        check({nm, " hits"}, out_hits, eh);
        check({nm, " popcount"}, $countones(out_map), out_hits);
        check({nm, " in_ready_done"}, in_ready, 0);
        @(negedge clk);
        check({nm, " out_valid_drop"}, out_valid, 0);
        check({nm, " busy_drop"}, busy, 0);
        $display("word %02h: map=%02h hits=%0d latency=%0d", d, out_map, out_hits, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;
        int stray;

        vecs[0] = '{8'hFF, 8'h1F, 4'd5};
        vecs[1] = '{8'h99, 8'h11, 4'd2};
        vecs[2] = '{8'h00, 8'h00, 4'd0};
        vecs[3] = '{8'hF6, 8'h10, 4'd1};
        vecs[4] = '{8'hA5, 8'h04, 4'd1};
        vecs[5] = '{8'h9F, 8'h13, 4'd3};
        vecs[6] = '{8'hF9, 8'h19, 4'd3};
        vecs[7] = '{8'h4F, 8'h09, 4'd2};
        vecs[8] = '{8'h36, 8'h00, 4'd0};
        vecs[9] = '{8'h92, 8'h12, 4'd2};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset out_map", out_map, 0);
        check("reset out_hits", out_hits, 0);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_word(vecs[i].data, vecs[i].map, vecs[i].hits, $sformatf("vec%0d", i));
        end

        // Back-to-back with in_valid held: second word waits for the first handshake.
        in_data  = 8'h00;
        in_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        in_data = 8'hF6;
        bad = 0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready !== 1'b0) bad++;
            @(negedge clk);
            lat++;
        end
        check("b2b first latency", lat, LAT);
        check("b2b first map", out_map, 8'h00);
        check("b2b first hits", out_hits, 0);
        check("b2b stall in_ready", bad, 0);
        check("b2b in_ready_at_done", in_ready, 0);
        $display("word 00: map=%02h hits=%0d latency=%0d", out_map, out_hits, lat);
        @(negedge clk);
        check("b2b second in_ready", in_ready, 1);
        check("b2b out_valid_gap", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        check("b2b second latency", lat, LAT);
        check("b2b second map", out_map, 8'h10);
        check("b2b second hits", out_hits, 1);
        $display("word f6: map=%02h hits=%0d latency=%0d", out_map, out_hits, lat);
        @(negedge clk);

        // Consumer stall for 20 cycles while another word is pending.
        out_ready = 1'b0;
        in_data   = 8'h99;
        in_valid  = 1'b1;
        wait_ready();
        @(negedge clk);
        in_data = 8'hFF;
        wait_result(lat);
        check("stall latency", lat, LAT);
        check("stall map", out_map, 8'h11);
        check("stall hits", out_hits, 2);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_map !== 8'h11 || out_hits !== 4'd2 || in_ready !== 1'b0)
                bad++;
        end
        check("stall hold", bad, 0);
        $display("word 99: held %0d cycles with out_ready low, unstable cycles=%0d", 20, bad);
        out_ready = 1'b1;
        @(negedge clk);
        check("stall release in_ready", in_ready, 1);
        check("stall release out_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        check("pending word latency", lat, LAT);
        check("pending word map", out_map, 8'h1F);
        check("pending word hits", out_hits, 5);
        $display("word ff: map=%02h hits=%0d latency=%0d", out_map, out_hits, lat);
        @(negedge clk);

        // Reset during the 4th SHIFT cycle (cycle 5 after acceptance).
        in_data  = 8'hFF;
        in_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midshift busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midshift reset in_ready", in_ready, 0);
        check("midshift reset out_valid", out_valid, 0);
        check("midshift reset busy", busy, 0);
        check("midshift reset map", out_map, 0);
        check("midshift reset hits", out_hits, 0);
        reset = 1'b0;
        #1;
        check("post reset in_ready", in_ready, 1);
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        check("no partial result", stray, 0);
        $display("reset mid-shift: stray out_valid cycles=%0d", stray);
        run_word(8'h90, 8'h10, 4'd1, "after_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
